// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state encoding and
// owner identifiers.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic FETCH = 1'b0;
   localparam logic DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way combinational grant between fetch (bit 0) and data (bit 1).
// A tie goes to data under fixed priority, otherwise to the port that did not win last.
module arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_prio_data,
   output logic [1:0] o_grant
);

   always_comb begin
      // NOTE: default assignment first so no path through the block can infer a latch.
      o_grant = 2'b00;
      if (i_req == 2'b11) begin
         if (i_prio_data || (i_last_grant == FETCH)) o_grant = 2'b10;
         else                                        o_grant = 2'b01;
      end else begin
         o_grant = i_req;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backend memory port between instruction fetch and data load/store.
// One transaction at a time: IDLE arbitration, BUSY handshake with watchdog, one-cycle RESP ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW        = 64,
   parameter int DW        = 64,
   parameter int TIMEOUT   = 255,
   parameter int PRIO_DATA = 0
) (
   input  logic          CLK,
   input  logic          resetl,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic          if_err,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic          d_err,
   output logic [DW-1:0] d_rdata,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic [DW-1:0] m_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        r_state;
   logic          r_last_grant;
   logic          r_owner;
   logic [CW-1:0] r_cnt;

   logic [1:0]    w_grant;
   logic          w_done;
   logic          w_err;
   logic [DW-1:0] w_resp_data;

   arb_rr2 u_arb (
      .i_req        ({d_req, if_req}),
      .i_last_grant (r_last_grant),
      .i_prio_data  (1'(PRIO_DATA)),
      .o_grant      (w_grant)
   );

   // r_cnt holds the BUSY cycles already elapsed, so TIMEOUT-1 marks the last allowed cycle.
   assign w_done      = m_ready || (r_cnt == CW'(TIMEOUT - 1));
   assign w_err       = !m_ready;
   assign w_resp_data = m_ready ? m_rdata : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         r_state      <= IDLE;
         r_last_grant <= FETCH;
         r_owner      <= FETCH;
         r_cnt        <= '0;
         m_req        <= 1'b0;
         m_we         <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         if_ack       <= 1'b0;
         if_err       <= 1'b0;
         if_rdata     <= '0;
         d_ack        <= 1'b0;
         d_err        <= 1'b0;
         d_rdata      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_grant) begin
                  r_owner      <= w_grant[1];
                  r_last_grant <= w_grant[1];
                  m_req        <= 1'b1;
                  m_we         <= w_grant[1] & d_we;
                  m_addr       <= w_grant[1] ? d_addr : if_addr;
                  m_wdata      <= w_grant[1] ? d_wdata : '0;
                  r_state      <= BUSY;
               end
            end
            BUSY: begin
               if (w_done) begin
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  m_addr  <= '0;
                  m_wdata <= '0;
                  r_cnt   <= '0;
                  r_state <= RESP;
                  if (r_owner == DATA) begin
                     d_ack   <= 1'b1;
                     d_err   <= w_err;
                     d_rdata <= w_resp_data;
                  end else begin
                     if_ack   <= 1'b1;
                     if_err   <= w_err;
                     if_rdata <= w_resp_data[31:0];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               if_ack   <= 1'b0;
               if_err   <= 1'b0;
               if_rdata <= '0;
               d_ack    <= 1'b0;
               d_err    <= 1'b0;
               d_rdata  <= '0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a backend model predicts each grant and response, a monitor checks every ack.
// A second instance with fixed data priority runs alongside under constant contention.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int TO = 8;

   logic CLK = 1'b0;
   logic resetl = 1'b0;
   always #5 CLK = ~CLK;

   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack, if_err;
   logic [31:0]   if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_ack, d_err;
   logic [DW-1:0] d_rdata;
   logic          m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .PRIO_DATA(0)) dut (
      .CLK(CLK), .resetl(resetl),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata)
   );

   // Fixed-priority instance: both ports request forever, backend always ready.
   logic          p_one = 1'b1;
   logic [AW-1:0] p_if_addr = 64'h80, p_d_addr = 64'h200;
   logic [DW-1:0] p_wdata = 64'h77, p_rdata = 64'h99;
   logic          p_if_ack, p_if_err, p_d_ack, p_d_err, p_m_req, p_m_we;
   logic [31:0]   p_if_rdata;
   logic [DW-1:0] p_d_rdata, p_m_wdata;
   logic [AW-1:0] p_m_addr;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .PRIO_DATA(1)) dut_prio (
      .CLK(CLK), .resetl(resetl),
      .if_req(p_one), .if_addr(p_if_addr), .if_ack(p_if_ack), .if_err(p_if_err), .if_rdata(p_if_rdata),
      .d_req(p_one), .d_we(p_one), .d_addr(p_d_addr), .d_wdata(p_wdata),
      .d_ack(p_d_ack), .d_err(p_d_err), .d_rdata(p_d_rdata),
      .m_req(p_m_req), .m_we(p_m_we), .m_addr(p_m_addr), .m_wdata(p_m_wdata),
      .m_ready(p_one), .m_rdata(p_rdata)
   );

   typedef struct {
      logic          owner;   // 0 = fetch, 1 = data
      logic          err;
      logic [DW-1:0] rdata;
      logic          we;
   } exp_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   exp_t          exp_q[$];
   int            lat_q[$];
   logic [DW-1:0] dat_q[$];
   logic          ack_log[$];
   logic          model_last = 1'b0;
   int            rst_gen = 0;
   int            prio_grants = 0;
   logic          snap_if = 1'b0, snap_d = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Requests as seen by the DUT at each edge; the edge before m_req rises is the grant edge.
   always @(posedge CLK) begin
      snap_if <= if_req;
      snap_d  <= d_req;
   end

   task automatic flush_model();
      exp_q.delete();
      model_last = 1'b0;
      rst_gen++;
   endtask

   task automatic do_reset();
      resetl = 1'b0;
      flush_model();
      repeat (2) @(negedge CLK);
      resetl = 1'b1;
   endtask

   task automatic wait_ack(input logic which, output int w);
      w = 0;
      do begin
         @(negedge CLK);
         w++;
      end while (!(which ? d_ack : if_ack) && w < 100);
      if (!(which ? d_ack : if_ack)) check(which ? "d_ack_wait" : "if_ack_wait", 1'b0, 1'b1);
   endtask

   task automatic fetch_txn(input logic [AW-1:0] a, input int gap, output int w);
      repeat (gap) @(negedge CLK);
      if_addr = a;
      if_req  = 1'b1;
      wait_ack(1'b0, w);
      if_req = 1'b0;
   endtask

   task automatic data_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int gap, output int w);
      repeat (gap) @(negedge CLK);
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
      wait_ack(1'b1, w);
      d_req = 1'b0;
   endtask

   // Backend: predicts the grant, checks the bus, answers after a chosen latency.
   initial begin : backend
      logic          prev, own, ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, dat;
      int            lat, g;
      exp_t          e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (m_req && !prev && resetl) begin
            g = rst_gen;
            check("grant_had_request", snap_if | snap_d, 1'b1);
            own = (snap_if && snap_d) ? !model_last : snap_d;
            model_last = own;
            ea  = own ? d_addr : if_addr;
            ewe = own ? d_we : 1'b0;
            ewd = own ? d_wdata : '0;
            if (lat_q.size() > 0) begin
               lat = lat_q.pop_front();
               dat = dat_q.pop_front();
            end else begin
               lat = $urandom_range(1, 10);
               dat = {$urandom, $urandom};
            end
            e.owner = own;
            e.err   = (lat > TO);
            e.rdata = (lat > TO) ? '0 : dat;
            e.we    = ewe;
            exp_q.push_back(e);
            for (int k = 1; k <= TO; k++) begin
               check("m_req_busy", m_req, 1'b1);
               check("m_addr", m_addr, ea);
               check("m_we", m_we, ewe);
               check("m_wdata", m_wdata, ewd);
               m_ready = (k == lat);
               m_rdata = (k == lat) ? dat : {$urandom, $urandom};
               @(negedge CLK);
               m_ready = 1'b0;
               if (g != rst_gen || k == lat) break;
            end
            if (g == rst_gen) begin
               check("m_req_dropped", m_req, 1'b0);
               check("ack_timing", own ? d_ack : if_ack, 1'b1);
            end
         end
         prev = m_req;
      end
   end

   // Monitor: pops one expectation per ack and checks the quiet state otherwise.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (resetl) begin
            if (!m_req) check("m_idle_zero", {m_we, |m_addr, |m_wdata}, 3'b0);
            if (if_ack || d_ack) begin
               ack_log.push_back(d_ack);
               if (exp_q.size() == 0) begin
                  check("ack_without_tx", {if_ack, d_ack}, 2'b00);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_if_owner", if_ack, !e.owner);
                  check("ack_d_owner", d_ack, e.owner);
                  if (e.owner) begin
                     check("d_err", d_err, e.err);
                     if (!e.we) check("d_rdata", d_rdata, e.rdata);
                  end else begin
                     check("if_err", if_err, e.err);
                     check("if_rdata", if_rdata, e.rdata[31:0]);
                  end
               end
            end else begin
               check("quiet_outputs", {if_err, d_err, |if_rdata, |d_rdata}, 4'b0);
            end
         end
      end
   end

   initial begin : prio_check
      logic prev1;
      prev1 = 1'b0;
      forever begin
         @(negedge CLK);
         if (resetl) begin
            if (p_m_req && !prev1) begin
               check("prio_grant_data", {p_m_we, p_m_addr}, {1'b1, p_d_addr});
               prio_grants++;
            end
            check("prio_no_fetch_ack", p_if_ack, 1'b0);
         end
         prev1 = p_m_req;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w;
      repeat (3) @(negedge CLK);
      check("rst_m_bus", {m_req, m_we, |m_addr, |m_wdata}, 4'b0);
      check("rst_if_out", {if_ack, if_err, |if_rdata}, 3'b0);
      check("rst_d_out", {d_ack, d_err, |d_rdata}, 3'b0);
      resetl = 1'b1;
      @(negedge CLK);

      // Lone fetch, minimum three-cycle transaction.
      lat_q.push_back(1); dat_q.push_back(64'h8B0203E8);
      fetch_txn(64'h40, 0, w);
      check("fetch_latency", w, 2);

      // Store with four BUSY cycles.
      lat_q.push_back(4); dat_q.push_back(64'h1234);
      data_txn(1'b1, 64'h100, 64'hDEADBEEF, 1, w);
      check("store_latency", w, 5);

      // Timeout, then a fresh request is accepted.
      lat_q.push_back(99); dat_q.push_back(64'hFFFF);
      fetch_txn(64'h80, 1, w);
      check("timeout_latency", w, TO + 1);
      lat_q.push_back(2); dat_q.push_back(64'h0BAD_F00D_0000_5555);
      data_txn(1'b0, 64'h108, 64'h0, 1, w);
      check("post_timeout_latency", w, 3);

      // m_ready on the last allowed cycle is a success.
      lat_q.push_back(TO); dat_q.push_back(64'hCAFEF00D_12345678);
      fetch_txn(64'hC0, 1, w);
      check("boundary_latency", w, TO + 1);

      // Tie from reset with both ports re-requesting continuously.
      do_reset();
      ack_log.delete();
      fork
         begin : tie_f
            int w1;
            fetch_txn(64'h400, 0, w1);
            fetch_txn(64'h408, 0, w1);
         end
         begin : tie_d
            int w2;
            data_txn(1'b0, 64'h500, 64'h0, 0, w2);
            data_txn(1'b1, 64'h508, 64'h55, 0, w2);
         end
      join
      @(negedge CLK);
      check("tie_count", ack_log.size(), 4);
      if (ack_log.size() >= 4)
         check("tie_order", {ack_log[0], ack_log[1], ack_log[2], ack_log[3]}, 4'b1010);

      // Asynchronous reset in the middle of BUSY.
      lat_q.push_back(50); dat_q.push_back(64'h0);
      @(negedge CLK);
      if_addr = 64'h1000;
      if_req  = 1'b1;
      w = 0;
      while (!m_req && w < 20) begin
         @(negedge CLK);
         w++;
      end
      check("rst_test_busy", m_req, 1'b1);
      #2;
      resetl = 1'b0;
      flush_model();
      d_addr = 64'h300; d_we = 1'b0; d_wdata = '0; d_req = 1'b1;
      #1;
      check("async_reset_m_req", m_req, 1'b0);
      check("async_reset_no_ack", {if_ack, d_ack}, 2'b00);
      @(negedge CLK);
      resetl = 1'b1;
      ack_log.delete();
      wait_ack(1'b1, w);
      d_req = 1'b0;
      wait_ack(1'b0, w);
      if_req = 1'b0;
      @(negedge CLK);
      check("post_reset_first_is_data", (ack_log.size() > 0) ? ack_log[0] : 1'b0, 1'b1);

      // Randomised traffic from both ports.
      fork
         begin : rnd_f
            int wf;
            for (int i = 0; i < 25; i++)
               fetch_txn({$urandom, $urandom} & ~64'h3, $urandom_range(0, 3), wf);
         end
         begin : rnd_d
            int wd;
            for (int i = 0; i < 25; i++)
               data_txn(1'($urandom_range(0, 1)), {$urandom, $urandom} & ~64'h7,
                        {$urandom, $urandom}, $urandom_range(0, 3), wd);
         end
      join
      repeat (5) @(negedge CLK);
      check("all_acked", exp_q.size(), 0);
      check("prio_grants_seen", prio_grants >= 10, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backend memory port between the instruction-fetch requester and the data load/store requester of the single-cycle core, so both can use one physical memory.
- Arbitrates between the two requesters, sequences one transaction at a time over a variable-latency ready handshake, and returns read data with a one-cycle acknowledge.
- A watchdog counter aborts backend transactions that stall too long.

Parameters:
- AW, 64, address width (bits)
- DW, 64, data width (bits)
- TIMEOUT, 255, maximum BUSY cycles without m_ready before abort (range 1..65535)
- PRIO_DATA, 0, 1 = data port always wins a tie; 0 = round-robin between the two ports

Ports:
- CLK  in  1  clock; all state changes on posedge
- resetl  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address; stable while if_req is high
- if_ack  out  1  one-cycle fetch completion pulse
- if_err  out  1  high together with if_ack when the fetch timed out
- if_rdata  out  32  fetch data, equal to m_rdata[31:0] as captured; valid while if_ack is high
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  high together with d_ack when the data access timed out
- d_rdata  out  DW  load data; valid while d_ack is high
- m_req  out  1  backend request, high throughout BUSY
- m_we  out  1  backend write enable
- m_addr  out  AW  backend address
- m_wdata  out  DW  backend write data
- m_ready  in  1  backend completion, sampled on posedge while BUSY
- m_rdata  in  DW  backend read data, valid when m_ready is high

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset (resetl low, asynchronous): state = IDLE.
  - All outputs 0.
  - last_grant = FETCH, so the first tie goes to data.
  - Timeout counter = 0; owner = FETCH.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests with PRIO_DATA=1: grant data.
  - Both requests with PRIO_DATA=0: grant the port that is not last_grant.
  - On a grant:
    - Latch owner, address, we and wdata into registers.
    - Go to BUSY and set last_grant = owner.
    - m_req/m_addr/m_we/m_wdata are driven from these registers starting the next cycle.
    - A fetch drives m_we = 0 and m_wdata = 0.
- BUSY:
  - m_req = 1 and the counter increments each cycle.
  - m_ready = 1 at a posedge:
    - Capture m_rdata, clear the counter, go to RESP with err = 0.
    - m_req drops in the same cycle.
  - Counter reaches TIMEOUT with m_ready still low:
    - Abort: captured data = 0, err = 1, go to RESP.
    - m_ready high on the TIMEOUT cycle itself counts as success.
- RESP:
  - The owner's ack is high for exactly one cycle; its err reflects the abort.
  - Its rdata holds the captured value for that cycle. For a store, the rdata value is don't-care, and the bench must ignore it.
  - The other port's ack/err stay 0.
  - Next state is IDLE unconditionally, so the owner's req (dropped after ack) cannot be re-granted.
  - The minimum transaction is 3 cycles: IDLE grant, BUSY with m_ready, RESP.
- Outputs:
  - ack/err/rdata are registered outputs, 0 outside RESP.
  - m_* are registered outputs, 0 outside BUSY.
- Requests are never dropped or reordered; a losing requester waits in IDLE arbitration.
- A requester deasserting req before its ack is a protocol violation and the behaviour is undefined. An in-flight transaction still completes.
- Reset in mid-transaction: return immediately to the reset values; no ack is issued for the aborted transaction.
- Counter width is clog2(TIMEOUT+1). It never wraps because it is cleared on leaving BUSY.

Decomposition:
- Shared package holds:
  - State encoding enum: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Owner constants: FETCH=1'b0, DATA=1'b1.
- Natural sub-module: arb_rr2, a combinational two-way grant.
  - Inputs: req pair, last_grant, prio_data.
  - Output: one-hot grant.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x40; m_ready=1 one cycle after m_req rises with m_rdata=0x8B0203E8 -> m_addr=0x40 and m_we=0; if_ack pulses once with if_rdata=0x8B0203E8 and if_err=0; d_ack stays 0.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF; m_ready after 4 BUSY cycles -> m_we=1 and m_wdata=0xDEADBEEF for all 4 cycles; d_ack pulses once; total 6 cycles from grant to ack.
- Tie, PRIO_DATA=0: both requesters re-request continuously (each re-raises req in the cycle after its ack) -> grants alternate DATA, FETCH, DATA, FETCH starting from reset; with PRIO_DATA=1 every grant is DATA.
- Timeout, TIMEOUT=8: fetch request, m_ready held 0 -> m_req high for exactly 8 cycles; then if_ack=1, if_err=1, if_rdata=0; the FSM accepts a new request afterwards.
- Boundary: m_ready rises on the 8th BUSY cycle with TIMEOUT=8 -> treated as success, err=0, data captured.
- Reset mid-BUSY: drop resetl asynchronously between edges -> m_req=0 immediately; no ack; after release a pending d_req is granted first.
